tt_um_vedic_div_8x4: RTL

Sequential 8-bit by 4-bit unsigned restoring divider in the standard TinyTapeout user-module wrapper. It is the inverse of the team's 4x4 Vedic multiplier: any product that macro emits (up to 225), together with one of its factors, recovers the other factor with remainder 0. One quotient bit is resolved per clock under a start/busy/done handshake on the bidirectional pins. The quotient or the remainder (with an error flag) is selected onto `uo_out`.

---
 rtl/tt_um_vedic_div_8x4.sv | 127 ++++++++++++
 1 files changed

// File: rtl/tt_um_vedic_div_8x4.sv
// tt_um_vedic_div_8x4: sequential 8-bit / 4-bit unsigned restoring divider,
// one quotient bit per enabled clock, in the TinyTapeout user-module wrapper.
// Optional build macro: DIV_ZERO_DETECT_EN. When it is defined, a zero divisor
// finishes one cycle after start with quotient FF, remainder 0 and err set.
// Without it, a zero divisor runs all 8 iterations.
module tt_um_vedic_div_8x4 (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [7:0]  dividend;
    logic [3:0]  divisor;
    logic [4:0]  part_rem;
    logic [7:0]  quot_acc;
    logic [2:0]  iter;
    logic [7:0]  quotient;
    logic [3:0]  remainder;
    logic        err;
    logic        busy;
    logic        done;

    logic        start;
    logic        rsel;
    logic        accept;
    logic        zero_trap;
    logic [4:0]  trial;
    logic        q_bit;
    logic [4:0]  next_rem;
    logic        unused_pins;

    assign start  = uio_in[4];
    assign rsel   = uio_in[5];
    assign accept = ena && start && (state == IDLE || state == DONE);
    assign unused_pins = &{1'b0, uio_in[7:6]};

`ifdef DIV_ZERO_DETECT_EN
    assign zero_trap = (divisor == 4'd0);
`else
    assign zero_trap = 1'b0;
`endif

    // One restoring step: bring down the next dividend bit and try to subtract.
    // The partial remainder is kept below the divisor, so the result fits in 4 bits;
    // with a zero divisor every compare succeeds and the trial passes through.
    always_comb begin
        trial    = {part_rem[3:0], dividend[7]};
        q_bit    = (trial >= {1'b0, divisor});
        next_rem = q_bit ? (trial - {1'b0, divisor}) : trial;
    end

    // Working registers: latch operands on accept, shift one bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            dividend <= ui_in;
            divisor  <= uio_in[3:0];
            part_rem <= 5'd0;
            quot_acc <= 8'd0;
            iter     <= 3'd0;
        end else if (ena && state == RUN) begin
            dividend <= {dividend[6:0], 1'b0};
            part_rem <= next_rem;
            quot_acc <= {quot_acc[6:0], q_bit};
            iter     <= iter + 3'd1;
        end
    end

    // Control FSM with registered busy/done and result registers that change only at completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            quotient  <= 8'd0;
            remainder <= 4'd0;
            err       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (zero_trap) begin
                        quotient  <= 8'hFF;
                        remainder <= 4'h0;
                        err       <= 1'b1;
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (iter == 3'd7) begin
                        quotient  <= {quot_acc[6:0], q_bit};
                        remainder <= next_rem[3:0];
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Output mux: rsel only chooses what is shown, it never touches state.
    always_comb begin
        uo_out  = rsel ? {err, 3'b000, remainder} : quotient;
        uio_out = {done, busy, 6'b00_0000};
        uio_oe  = 8'b1100_0000;
    end

endmodule
